alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential issue/result controller on the driving side of the processor's ALU. Accepts one decoded-from-raw MIPS instruction plus register operands over a valid/ready handshake, maps it to the ALU's 6-bit func code and operands, and waits for the ALU to settle. It then captures `out` and `zero` and returns a writeback/branch result over a second valid/ready handshake. It sits between register read and writeback/PC-update in the multi-cycle datapath.

Parameters:
- `ALU_WAIT`, default 1: cycles between driving the ALU inputs and sampling `alu_out`/`alu_zero`; legal values 1..7.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction/operands valid.
- `in_ready`  out  1  controller can accept an instruction.
- `instr`  in  32  raw MIPS instruction word.
- `rs_val`  in  32  GPR[rs].
- `rt_val`  in  32  GPR[rt].
- `pc`  in  32  address of the instruction.
- `alu_a`  out  32  to ALU input1.
- `alu_b`  out  32  to ALU input2.
- `alu_func`  out  6  to ALU func.
- `alu_out`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag; captured and exported only, never used for decisions.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  32  writeback data.
- `res_dest`  out  5  destination GPR.
- `res_we`  out  1  write enable.
- `br_taken`  out  1  branch taken.
- `br_target`  out  32  branch target.
- `illegal`  out  1  unsupported instruction.

Behaviour:
- **Clocking and reset.** One clock `clk`; reset `rst_n` is asynchronous and active-low.
- **Reset values.** State=IDLE; `in_ready`=1; `alu_a`=0; `alu_b`=0; `alu_func`=6'b100001 (addu, also the idle value); `res_valid`=0; `res_data`=0; `res_dest`=0; `res_we`=0; `br_taken`=0; `br_target`=0; `illegal`=0.
- **FSM states:** IDLE, EXEC, RESP.
  - IDLE: `in_ready`=1. On `in_valid`, register the decode → EXEC; illegal decode → RESP directly.
  - EXEC: `in_ready`=0. Hold `alu_a`/`alu_b`/`alu_func` stable. A 3-bit counter runs `ALU_WAIT` cycles; on the last cycle, sample `alu_out` → RESP.
  - RESP: `res_valid`=1; all `res_*`, `br_*` and `illegal` are held stable until `res_valid`&&`res_ready` → IDLE, with `res_valid` dropping the next cycle. No new instruction is accepted in RESP.
- **Latency.** Accept edge to `res_valid` = `ALU_WAIT`+1 cycles; illegal instructions take 1 cycle.
- **R-type (op 000000), func = funct:**
  - addu, subu, sub, and, or, xor, nor, slt, sllv, srlv, mult, div: `a`=`rs_val`, `b`=`rt_val`.
  - sll/srl: issued as sllv/srlv with `a`={27'b0,shamt}, `b`=`rt_val`.
  - sra and all other functs: illegal.
  - `dest`=rd.
- **I-type, `b`=imm extended, `dest`=rt:**
  - addiu 001001 → 100001, sign-extend.
  - slti 001010 → 101010, sign-extend.
  - andi 001100 → 100100, zero-extend.
  - ori 001101 → 100101, zero-extend.
  - xori 001110 → 100110, zero-extend.
  - lui 001111 → 111101, `b`={16'b0,imm}.
- **Branches, `res_we`=0, decided solely from captured out==0:**
  - beq 000100: sub rs,rt; taken=(out==0).
  - bne 000101: sub rs,rt; taken=(out!=0).
  - blez 000110: slt with `a`=0, `b`=rs; taken=(out==0).
  - bgtz 000111: slt with `a`=0, `b`=rs; taken=(out!=0).
  - bgez (op 000001, rt=00001): slt with `a`=rs, `b`=0; taken=(out==0).
  - Other REGIMM rt values: illegal.
- **Branch target.** `br_target`=`pc`+4+(sext(imm)<<2), computed modulo 2^32 (wraps), valid for branches only; 0 otherwise.
- **Writeback.** `res_we`=1 only for legal non-branch instructions with dest≠0; `res_data`=captured `alu_out`.
- **Illegal instructions.** `illegal`=1, `res_we`=0, `br_taken`=0, `res_data`=0. The ALU is not driven; it holds its idle values.
- **`rst_n` low mid-EXEC/RESP:** immediate return to reset values; the in-flight instruction is dropped.
- **`in_valid` while `in_ready`=0:** ignored; the upstream must hold its request.

Optional Feature:
- Macro `DIV_ZERO_TRAP_EN`.
  - Defined: div with `rt_val`==0 is not issued and is reported as illegal (1-cycle path, `res_we`=0).
  - Undefined: div by zero is issued normally and the ALU's `out` is written back as-is.

Test Plan:
- addu rd=3, rs_val=5, rt_val=7, `ALU_WAIT`=1, ALU model returns 12 → `alu_func`=100001, `res_valid` 2 cycles after accept, `res_data`=12, `res_dest`=3, `res_we`=1.
- beq, rs_val=rt_val=0x10, imm=0xFFFF, pc=0x100 → `alu_func`=100010, `br_taken`=1, `br_target`=0x100, `res_we`=0.
- bgtz, rs_val=0xFFFFFFFF; then bgez, rs_val=0 → `br_taken`=0 for the first, `br_taken`=1 for the second.
- lui rt=4, imm=0x1234 → `alu_b`=0x00001234, `alu_func`=111101, `res_data`=0x12340000; sll rd=0 (nop) → `res_we`=0.
- Opcode 111111 → `illegal`=1 one cycle after accept, ALU inputs unchanged; div with rt_val=0 → `illegal`=1 only when `DIV_ZERO_TRAP_EN` is defined.
- `res_ready` low 5 cycles, then `rst_n` pulsed low during RESP → outputs stable while stalled, then all reset values asynchronously, `in_ready`=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue/result controller: decodes MIPS instructions, drives the ALU, returns writeback/branch results
// Optional build macro: DIV_ZERO_TRAP_EN (div with rt_val==0 is reported as illegal instead of being issued).
module alu_issue_ctrl #(
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] pc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_dest,
  output logic        res_we,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [2:0] WAIT_LAST = 3'(ALU_WAIT);

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_LUI  = 6'b111101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;

  // Decoded instruction, held until the ALU result is sampled
  logic [4:0]  p_dest;
  logic        p_we;
  logic        p_branch;
  logic        p_ne;
  logic [31:0] p_target;

  logic        d_legal;
  logic [5:0]  d_func;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [4:0]  d_dest;
  logic        d_branch;
  logic        d_ne;
  logic        d_we;
  logic [31:0] d_target;

  logic [5:0]  op;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op    = instr[31:26];
  assign rt_f  = instr[20:16];
  assign rd_f  = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'b0, imm};

  // rs arrives pre-read as rs_val; the zero flag is informational because
  // branch outcomes are derived from the captured result itself.
  logic unused_inputs;
  assign unused_inputs = ^{instr[25:21], alu_zero};

  // Map the raw instruction onto ALU func/operands, destination and branch kind
  always_comb begin
    d_legal  = 1'b1;
    d_func   = F_ADDU;
    d_a      = rs_val;
    d_b      = rt_val;
    d_dest   = rt_f;
    d_branch = 1'b0;
    d_ne     = 1'b0;
    case (op)
      6'b000000: begin
        d_dest = rd_f;
        case (funct)
          F_ADDU, F_SUBU, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT,
          F_SLLV, F_SRLV, F_MULT: d_func = funct;
          F_DIV: begin
            d_func = F_DIV;
`ifdef DIV_ZERO_TRAP_EN
            if (rt_val == 32'd0) d_legal = 1'b0;
`else
            d_legal = 1'b1;
`endif
          end
          F_SLL: begin
            d_func = F_SLLV;
            d_a    = {27'b0, shamt};
          end
          F_SRL: begin
            d_func = F_SRLV;
            d_a    = {27'b0, shamt};
          end
          default: d_legal = 1'b0;
        endcase
      end
      6'b001001: begin d_func = F_ADDU; d_b = sext; end
      6'b001010: begin d_func = F_SLT;  d_b = sext; end
      6'b001100: begin d_func = F_AND;  d_b = zext; end
      6'b001101: begin d_func = F_OR;   d_b = zext; end
      6'b001110: begin d_func = F_XOR;  d_b = zext; end
      6'b001111: begin d_func = F_LUI;  d_b = zext; end
      6'b000100: begin d_func = F_SUB; d_branch = 1'b1; end
      6'b000101: begin d_func = F_SUB; d_branch = 1'b1; d_ne = 1'b1; end
      6'b000110: begin
        d_func = F_SLT; d_a = 32'd0; d_b = rs_val; d_branch = 1'b1;
      end
      6'b000111: begin
        d_func = F_SLT; d_a = 32'd0; d_b = rs_val; d_branch = 1'b1; d_ne = 1'b1;
      end
      6'b000001: begin
        if (rt_f == 5'b00001) begin
          d_func = F_SLT; d_a = rs_val; d_b = 32'd0; d_branch = 1'b1;
        end else begin
          d_legal = 1'b0;
        end
      end
      default: d_legal = 1'b0;
    endcase
  end

  assign d_we     = d_legal && !d_branch && (d_dest != 5'd0);
  assign d_target = pc + 32'd4 + {sext[29:0], 2'b00};

  // Issue FSM: accept, hold ALU inputs for ALU_WAIT cycles, then present the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      in_ready  <= 1'b1;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_func  <= F_ADDU;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_dest  <= 5'd0;
      res_we    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= 32'd0;
      illegal   <= 1'b0;
      p_dest    <= 5'd0;
      p_we      <= 1'b0;
      p_branch  <= 1'b0;
      p_ne      <= 1'b0;
      p_target  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (d_legal) begin
              alu_a    <= d_a;
              alu_b    <= d_b;
              alu_func <= d_func;
              p_dest   <= d_dest;
              p_we     <= d_we;
              p_branch <= d_branch;
              p_ne     <= d_ne;
              p_target <= d_branch ? d_target : 32'd0;
              cnt      <= 3'd1;
              state    <= EXEC;
            end else begin
              // Illegal: ALU keeps its idle inputs, answer next cycle
              res_valid <= 1'b1;
              res_data  <= 32'd0;
              res_dest  <= 5'd0;
              res_we    <= 1'b0;
              br_taken  <= 1'b0;
              br_target <= 32'd0;
              illegal   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == WAIT_LAST) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_dest  <= p_dest;
            res_we    <= p_we;
            br_taken  <= p_branch && ((alu_out == 32'd0) ^ p_ne);
            br_target <= p_target;
            illegal   <= 1'b0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_func  <= F_ADDU;
            state     <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_func;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dest;
  logic        res_we;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  int vectors;
  int miscompares;

  alu_issue_ctrl #(.ALU_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .pc(pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_dest(res_dest), .res_we(res_we),
    .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_func)
      6'b100001: alu_out = alu_a + alu_b;
      6'b100010,
      6'b100011: alu_out = alu_a - alu_b;
      6'b100100: alu_out = alu_a & alu_b;
      6'b100101: alu_out = alu_a | alu_b;
      6'b100110: alu_out = alu_a ^ alu_b;
      6'b100111: alu_out = ~(alu_a | alu_b);
      6'b101010: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      6'b000100: alu_out = alu_b << alu_a[4:0];
      6'b000110: alu_out = alu_b >> alu_a[4:0];
      6'b011000: alu_out = alu_a * alu_b;
      6'b011010: alu_out = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      6'b111101: alu_out = alu_b << 16;
      default:   alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] p);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_ready", in_ready, 1'b1);
    instr    = i;
    rs_val   = rs;
    rt_val   = rt;
    pc       = p;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("drop_valid", res_valid, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    instr = 32'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    pc = 32'd0;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_alu_func", alu_func, 6'b100001);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_br_target", br_target, 32'd0);
    rst_n = 1'b1;
    step();

    // addu r3 = 5 + 7
    issue(32'h0022_1821, 32'd5, 32'd7, 32'h0);
    check("addu_func", alu_func, 6'b100001);
    check("addu_a", alu_a, 32'd5);
    check("addu_b", alu_b, 32'd7);
    check("addu_early", res_valid, 1'b0);
    check("addu_busy", in_ready, 1'b0);
    step();
    check("addu_valid", res_valid, 1'b1);
    check("addu_data", res_data, 32'd12);
    check("addu_dest", res_dest, 5'd3);
    check("addu_we", res_we, 1'b1);
    check("addu_br", br_taken, 1'b0);
    consume();

    // beq equal, backwards by one word
    issue(32'h1022_FFFF, 32'h10, 32'h10, 32'h100);
    check("beq_func", alu_func, 6'b100010);
    step();
    check("beq_taken", br_taken, 1'b1);
    check("beq_target", br_target, 32'h100);
    check("beq_we", res_we, 1'b0);
    consume();

    // bgtz with negative rs: not taken
    issue(32'h1C20_0004, 32'hFFFF_FFFF, 32'd0, 32'h200);
    check("bgtz_func", alu_func, 6'b101010);
    check("bgtz_a", alu_a, 32'd0);
    check("bgtz_b", alu_b, 32'hFFFF_FFFF);
    step();
    check("bgtz_taken", br_taken, 1'b0);
    check("bgtz_target", br_target, 32'h214);
    consume();

    // bgez with rs = 0: taken
    issue(32'h0421_FFFE, 32'd0, 32'd0, 32'h300);
    step();
    check("bgez_taken", br_taken, 1'b1);
    check("bgez_target", br_target, 32'h2FC);
    check("bgez_we", res_we, 1'b0);
    consume();

    // lui r4, 0x1234
    issue(32'h3C04_1234, 32'd0, 32'd0, 32'h0);
    check("lui_b", alu_b, 32'h0000_1234);
    check("lui_func", alu_func, 6'b111101);
    step();
    check("lui_data", res_data, 32'h1234_0000);
    check("lui_dest", res_dest, 5'd4);
    consume();

    // nop (sll r0)
    issue(32'h0000_0000, 32'd0, 32'd0, 32'h0);
    check("nop_func", alu_func, 6'b000100);
    step();
    check("nop_we", res_we, 1'b0);
    consume();

    // sll r5 = r2 << 4
    issue(32'h0002_2900, 32'd0, 32'd3, 32'h0);
    check("sll_a", alu_a, 32'd4);
    step();
    check("sll_data", res_data, 32'h30);
    check("sll_we", res_we, 1'b1);
    consume();

    // andi r3 with zero-extended 0x8000
    issue(32'h3023_8000, 32'hFFFF_FFFF, 32'd0, 32'h0);
    check("andi_b", alu_b, 32'h0000_8000);
    step();
    check("andi_data", res_data, 32'h0000_8000);
    consume();

    // sra is unsupported
    issue(32'h0000_0003, 32'd1, 32'd2, 32'h0);
    check("sra_illegal", illegal, 1'b1);
    check("sra_valid", res_valid, 1'b1);
    consume();

    // opcode 111111: illegal in one cycle, ALU left idle
    issue(32'hFC00_0000, 32'd9, 32'd9, 32'h0);
    check("op3f_illegal", illegal, 1'b1);
    check("op3f_valid", res_valid, 1'b1);
    check("op3f_alu_a", alu_a, 32'd0);
    check("op3f_alu_b", alu_b, 32'd0);
    check("op3f_func", alu_func, 6'b100001);
    check("op3f_we", res_we, 1'b0);
    check("op3f_data", res_data, 32'd0);
    consume();

    // div r6 = 9 / 0
    issue(32'h0022_301A, 32'd9, 32'd0, 32'h0);
`ifdef DIV_ZERO_TRAP_EN
    check("div0_illegal", illegal, 1'b1);
    check("div0_we", res_we, 1'b0);
`else
    check("div0_func", alu_func, 6'b011010);
    step();
    check("div0_illegal", illegal, 1'b0);
    check("div0_data", res_data, 32'hFFFF_FFFF);
    check("div0_we", res_we, 1'b1);
`endif
    consume();

    // addiu r7 = 10 + (-1), then stall and reset during RESP
    issue(32'h2427_FFFF, 32'd10, 32'd0, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", res_valid, 1'b1);
      check("stall_data", res_data, 32'd9);
      check("stall_dest", res_dest, 5'd7);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", res_valid, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_data", res_data, 32'd0);
    check("arst_dest", res_dest, 5'd0);
    check("arst_we", res_we, 1'b0);
    check("arst_func", alu_func, 6'b100001);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
